// File: rtl/id_pkg.sv
// Decode-stage shared definitions: instruction field positions, ID/EX payload, immediate helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package id_pkg;

    // Default widths; the ID/EX payload struct is sized from these.
    localparam int ID_XLEN   = 32;
    localparam int ID_AW     = 5;
    localparam int ID_CTRL_W = 16;

    // Instruction is numbered [0:31] with bit 0 as the MSB.
    localparam int RS_MSB  = 6;
    localparam int RS_LSB  = 10;
    localparam int RT_MSB  = 11;
    localparam int RT_LSB  = 15;
    localparam int RD_MSB  = 16;
    localparam int RD_LSB  = 20;
    localparam int IMM_MSB = 16;
    localparam int IMM_LSB = 31;

    typedef struct packed {
        logic [ID_XLEN-1:0]   operand_a;
        logic [ID_XLEN-1:0]   operand_b;
        logic [ID_XLEN-1:0]   store_dat;
        logic [ID_AW-1:0]     dst;
        logic                 reg_wr;
        logic                 mem_to_reg;
        logic [ID_CTRL_W-1:0] ctrl;
    } id_ex_t;

    // Widen a 16-bit immediate; bit 15 is the sign when sign_ext is set.
    function automatic logic [ID_XLEN-1:0] ext_imm(input logic [15:0] imm16,
                                                   input logic        sign_ext);
        if (sign_ext)
            return {{(ID_XLEN-16){imm16[15]}}, imm16};
        return {{(ID_XLEN-16){1'b0}}, imm16};
    endfunction

endpackage

// File: rtl/gpr_file_bypass.sv
// GPR file: 2 combinational read ports, 1 write port, r0 reads zero, same-cycle write-back forward.
// Latency: reads 0 cycles (bypass covers the write landing this edge); write commits at the edge.
// Backpressure: none; writes are never refused.
// Ports: i_reset_n clears all registers synchronously; i_rs/i_rt_addr -> o_rs/o_rt_dat; i_wb_* write port.
module gpr_file_bypass #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            i_reset_n,
    input  logic [AW-1:0]   i_rs_addr,
    input  logic [AW-1:0]   i_rt_addr,
    input  logic            i_wb_en,
    input  logic [AW-1:0]   i_wb_addr,
    input  logic [XLEN-1:0] i_wb_data,
    output logic [XLEN-1:0] o_rs_dat,
    output logic [XLEN-1:0] o_rt_dat
);

    localparam int NUM_REGS = 2**AW;

    logic [XLEN-1:0] r_regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            for (int k = 0; k < NUM_REGS; k++)
                r_regs[k] <= '0;
        end else if (i_wb_en && (i_wb_addr != '0)) begin
            r_regs[i_wb_addr] <= i_wb_data;
        end
    end

    // r0 is forced to zero on read so a stray write-back to it can never leak out.
    assign o_rs_dat = (i_rs_addr == '0) ? '0 :
                      (i_wb_en && (i_wb_addr == i_rs_addr)) ? i_wb_data : r_regs[i_rs_addr];
    assign o_rt_dat = (i_rt_addr == '0) ? '0 :
                      (i_wb_en && (i_wb_addr == i_rt_addr)) ? i_wb_data : r_regs[i_rt_addr];

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: GPR read with bypass, immediate build, load-use hold, one registered ID/EX entry.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: in_ready drops on flush, load-use hazard, or a full entry that EX is not draining.
// Ports: in_* from fetch (valid/ready), wb_* write-back, flush redirect, out_* ID/EX entry (valid/ready).
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int XLEN           = ID_XLEN,
    parameter int AW             = ID_AW,
    parameter int CTRL_W         = ID_CTRL_W,
    parameter int LOAD_USE_STALL = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:31]       in_instr,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_alu_src,
    input  logic              in_ext_op,
    input  logic              in_imm_zero,
    input  logic              in_reg_dst,
    input  logic              in_reg_wr,
    input  logic              in_mem_to_reg,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_operand_a,
    output logic [XLEN-1:0]   out_operand_b,
    output logic [XLEN-1:0]   out_store_dat,
    output logic [AW-1:0]     out_dst,
    output logic              out_reg_wr,
    output logic              out_mem_to_reg,
    output logic [CTRL_W-1:0] out_ctrl
);

    localparam int HZ_W = (LOAD_USE_STALL > 0) ? $clog2(LOAD_USE_STALL + 1) : 1;

    logic [AW-1:0]   w_rs;
    logic [AW-1:0]   w_rt;
    logic [AW-1:0]   w_rd;
    logic [AW-1:0]   w_dst;
    logic [XLEN-1:0] w_rs_dat;
    logic [XLEN-1:0] w_rt_dat;
    logic [15:0]     w_imm16;
    logic [XLEN-1:0] w_imm;
    logic            w_wb_hits_hz;
    logic            w_stall;
    logic            w_accept;
    logic            w_is_load;
    logic            w_unused;
    id_ex_t          w_idex_nxt;

    logic            r_out_valid;
    id_ex_t          r_idex;
    logic [HZ_W-1:0] r_hz_cnt;
    logic [AW-1:0]   r_hz_dst;

    assign w_rs     = AW'(in_instr[RS_MSB:RS_LSB]);
    assign w_rt     = AW'(in_instr[RT_MSB:RT_LSB]);
    assign w_rd     = AW'(in_instr[RD_MSB:RD_LSB]);
    assign w_unused = ^in_instr[0:RS_MSB-1];

    gpr_file_bypass #(
        .XLEN (XLEN),
        .AW   (AW)
    ) u_gpr (
        .clk       (clk),
        .i_reset_n (reset),
        .i_rs_addr (w_rs),
        .i_rt_addr (w_rt),
        .i_wb_en   (wb_en),
        .i_wb_addr (wb_addr),
        .i_wb_data (wb_data),
        .o_rs_dat  (w_rs_dat),
        .o_rt_dat  (w_rt_dat)
    );

    assign w_imm16 = in_imm_zero ? 16'h0000 : in_instr[IMM_MSB:IMM_LSB];
    assign w_imm   = ext_imm(w_imm16, in_ext_op);
    assign w_dst   = in_reg_wr ? (in_reg_dst ? w_rd : w_rt) : '0;

    // A write-back to the loaded register this cycle is forwarded by the GPR
    // bypass, so the dependent instruction need not wait any longer.
    assign w_wb_hits_hz = wb_en && (wb_addr == r_hz_dst);
    assign w_stall      = (r_hz_cnt != '0) && ((w_rs == r_hz_dst) || (w_rt == r_hz_dst))
                          && !w_wb_hits_hz;

    assign in_ready  = reset && !flush && !w_stall && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_is_load = in_reg_wr && in_mem_to_reg && (w_dst != '0) && (LOAD_USE_STALL > 0);

    always_comb begin
        w_idex_nxt            = '0;
        w_idex_nxt.operand_a  = w_rs_dat;
        w_idex_nxt.operand_b  = in_alu_src ? w_imm : w_rt_dat;
        w_idex_nxt.store_dat  = w_rt_dat;
        w_idex_nxt.dst        = w_dst;
        w_idex_nxt.reg_wr     = in_reg_wr;
        w_idex_nxt.mem_to_reg = in_mem_to_reg;
        w_idex_nxt.ctrl       = in_ctrl;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_idex      <= '0;
            r_hz_cnt    <= '0;
            r_hz_dst    <= '0;
        end else begin
            if (flush)
                r_out_valid <= 1'b0;
            else if (w_accept)
                r_out_valid <= 1'b1;
            else if (out_ready)
                r_out_valid <= 1'b0;

            if (w_accept)
                r_idex <= w_idex_nxt;

            // A newly issued load restarts the window even if an older one is pending.
            if (flush) begin
                r_hz_cnt <= '0;
            end else if (w_accept && w_is_load) begin
                r_hz_cnt <= HZ_W'(LOAD_USE_STALL);
                r_hz_dst <= w_dst;
            end else if (w_wb_hits_hz) begin
                r_hz_cnt <= '0;
            end else if (r_hz_cnt != '0) begin
                r_hz_cnt <= r_hz_cnt - 1'b1;
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign out_operand_a  = r_idex.operand_a;
    assign out_operand_b  = r_idex.operand_b;
    assign out_store_dat  = r_idex.store_dat;
    assign out_dst        = r_idex.dst;
    assign out_reg_wr     = r_idex.reg_wr;
    assign out_mem_to_reg = r_idex.mem_to_reg;
    assign out_ctrl       = r_idex.ctrl;

endmodule

// File: tb/tb_id_stage_pipe.sv
module tb_id_stage_pipe;

    localparam int LUS = 1;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [0:31] in_instr;
    logic [15:0] in_ctrl;
    logic        in_alu_src, in_ext_op, in_imm_zero, in_reg_dst, in_reg_wr, in_mem_to_reg;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_operand_a, out_operand_b, out_store_dat;
    logic [4:0]  out_dst;
    logic        out_reg_wr, out_mem_to_reg;
    logic [15:0] out_ctrl;

    id_stage_pipe #(
        .XLEN(32), .AW(5), .CTRL_W(16), .LOAD_USE_STALL(LUS)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_ctrl(in_ctrl),
        .in_alu_src(in_alu_src), .in_ext_op(in_ext_op), .in_imm_zero(in_imm_zero),
        .in_reg_dst(in_reg_dst), .in_reg_wr(in_reg_wr), .in_mem_to_reg(in_mem_to_reg),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_operand_a(out_operand_a), .out_operand_b(out_operand_b),
        .out_store_dat(out_store_dat), .out_dst(out_dst), .out_reg_wr(out_reg_wr),
        .out_mem_to_reg(out_mem_to_reg), .out_ctrl(out_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_gpr [32];
    logic        m_valid;
    logic [31:0] m_a, m_b, m_st;
    logic [4:0]  m_dst;
    logic        m_rw, m_m2r;
    logic [15:0] m_ctrl;
    int          m_hz_left;    // cycles the last issued load still blocks its readers
    logic [4:0]  m_hz_dst;

    function automatic logic [31:0] iv();
        logic [31:0] v;
        v = in_instr;          // bit 0 of the instruction becomes bit 31 here
        return v;
    endfunction
    function automatic logic [4:0] f_rs(); return 5'((iv() >> 21) & 32'h1F); endfunction
    function automatic logic [4:0] f_rt(); return 5'((iv() >> 16) & 32'h1F); endfunction
    function automatic logic [4:0] f_rd(); return 5'((iv() >> 11) & 32'h1F); endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wb_en && wb_addr == a) return wb_data;
        return m_gpr[a];
    endfunction

    function automatic logic m_ready();
        logic blocked;
        blocked = (m_hz_left > 0) && (f_rs() == m_hz_dst || f_rt() == m_hz_dst)
                  && !(wb_en && wb_addr == m_hz_dst);
        return reset && !flush && !blocked && (!m_valid || out_ready);
    endfunction

    always @(posedge clk) begin : model
        logic        acc, wbhit;
        logic [31:0] imm, a, b, st;
        logic [4:0]  dst;
        acc   = in_valid && m_ready();
        wbhit = wb_en && (wb_addr == m_hz_dst);
        imm   = in_imm_zero ? 32'h0 : (iv() & 32'hFFFF);
        if (in_ext_op && imm >= 32'h8000) imm = imm | 32'hFFFF0000;
        a   = m_read(f_rs());
        st  = m_read(f_rt());
        b   = in_alu_src ? imm : st;
        dst = !in_reg_wr ? 5'd0 : (in_reg_dst ? f_rd() : f_rt());
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
            m_valid = 0; m_a = 0; m_b = 0; m_st = 0; m_dst = 0;
            m_rw = 0; m_m2r = 0; m_ctrl = 0; m_hz_left = 0; m_hz_dst = 0;
        end else begin
            if (wb_en && wb_addr != 0) m_gpr[wb_addr] = wb_data;
            if (flush) begin
                m_valid   = 0;
                m_hz_left = 0;
            end else begin
                if (acc) begin
                    m_valid = 1; m_a = a; m_b = b; m_st = st; m_dst = dst;
                    m_rw = in_reg_wr; m_m2r = in_mem_to_reg; m_ctrl = in_ctrl;
                end else if (out_ready) begin
                    m_valid = 0;
                end
                if (acc && in_reg_wr && in_mem_to_reg && dst != 0 && LUS > 0) begin
                    m_hz_left = LUS;
                    m_hz_dst  = dst;
                end else if (wbhit) begin
                    m_hz_left = 0;
                end else if (m_hz_left > 0) begin
                    m_hz_left--;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_in_ready", in_ready, m_ready());
            check("m_out_valid", out_valid, m_valid);
            check("m_operand_a", out_operand_a, m_a);
            check("m_operand_b", out_operand_b, m_b);
            check("m_store_dat", out_store_dat, m_st);
            check("m_dst", out_dst, m_dst);
            check("m_reg_wr", out_reg_wr, m_rw);
            check("m_mem_to_reg", out_mem_to_reg, m_m2r);
            check("m_ctrl", out_ctrl, m_ctrl);
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [0:31] mk(input int rs, input int rt, input logic [15:0] imm);
        logic [31:0] v;
        v = ((rs & 31) << 21) | ((rt & 31) << 16) | {16'h0, imm};
        return v;
    endfunction

    task automatic idle();
        in_valid = 0; in_instr = '0; in_ctrl = '0; in_alu_src = 0; in_ext_op = 0;
        in_imm_zero = 0; in_reg_dst = 0; in_reg_wr = 0; in_mem_to_reg = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0; flush = 0; out_ready = 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset = 0;
        in_valid = 1;
        step();
        cmp_en = 1;
        repeat (3) begin
            @(negedge clk);
            check("rst_out_valid", out_valid, 0);
            check("rst_in_ready", in_ready, 0);
            check("rst_operand_a", out_operand_a, 0);
            step();
        end
        reset = 1;
        in_instr = mk(5, 5, 16'h0);
        @(negedge clk);
        check("rel_in_ready", in_ready, 1);
        step();
        @(negedge clk);
        check("rd_r5_valid", out_valid, 1);
        check("rd_r5_a", out_operand_a, 0);
        check("rd_r5_b", out_operand_b, 0);

        // write-back forwarded to the instruction accepted on the same edge
        step();
        wb_en = 1; wb_addr = 3; wb_data = 32'hDEADBEEF;
        in_instr = mk(3, 0, 16'h0);
        step();
        wb_en = 0;
        @(negedge clk);
        check("bypass_a", out_operand_a, 32'hDEADBEEF);
        in_instr = mk(0, 3, 16'h0);
        step();
        @(negedge clk);
        check("gpr_commit_b", out_operand_b, 32'hDEADBEEF);

        // immediate extension
        in_alu_src = 1; in_ext_op = 1; in_instr = mk(0, 0, 16'h8001);
        step();
        @(negedge clk);
        check("imm_sext", out_operand_b, 32'hFFFF8001);
        in_ext_op = 0;
        step();
        @(negedge clk);
        check("imm_zext", out_operand_b, 32'h00008001);
        in_imm_zero = 1;
        step();
        @(negedge clk);
        check("imm_zero", out_operand_b, 32'h0);
        in_imm_zero = 0;

        // load r7 then a reader of r7
        in_instr = mk(0, 7, 16'h0010); in_reg_dst = 0; in_reg_wr = 1; in_mem_to_reg = 1;
        step();
        in_instr = mk(7, 0, 16'h4800); in_reg_dst = 1; in_mem_to_reg = 0; in_alu_src = 0;
        repeat (LUS) begin
            @(negedge clk);
            check("lu_stall", in_ready, 0);
            check("lu_load_dst", out_dst, 7);
            step();
        end
        @(negedge clk);
        check("lu_release", in_ready, 1);
        step();
        @(negedge clk);
        check("lu_issue_valid", out_valid, 1);
        check("lu_issue_dst", out_dst, 9);

        // load r7 then a reader of r8: no hold
        in_instr = mk(0, 7, 16'h0010); in_reg_dst = 0; in_mem_to_reg = 1; in_alu_src = 1;
        step();
        in_instr = mk(8, 0, 16'h0); in_mem_to_reg = 0; in_alu_src = 0;
        @(negedge clk);
        check("lu_nomatch_ready", in_ready, 1);
        step();

        // backpressure
        in_instr = mk(0, 0, 16'h0042); in_alu_src = 1; in_reg_wr = 0; in_ctrl = 16'hA5A5;
        step();
        out_ready = 0;
        in_instr = mk(0, 0, 16'h1234); in_ctrl = 16'h5A5A;
        repeat (4) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
            check("bp_hold_b", out_operand_b, 32'h42);
            check("bp_hold_ctrl", out_ctrl, 16'hA5A5);
            step();
        end
        out_ready = 1;
        @(negedge clk);
        check("bp_release_ready", in_ready, 1);
        step();
        @(negedge clk);
        check("bp_next_b", out_operand_b, 32'h1234);
        check("bp_next_ctrl", out_ctrl, 16'h5A5A);

        // flush with a pending load hold
        in_instr = mk(0, 7, 16'h0); in_reg_wr = 1; in_mem_to_reg = 1; in_alu_src = 1;
        step();
        in_instr = mk(7, 7, 16'h0); in_mem_to_reg = 0; in_alu_src = 0;
        flush = 1;
        @(negedge clk);
        check("fl_in_ready_low", in_ready, 0);
        step();
        flush = 0;
        @(negedge clk);
        check("fl_valid", out_valid, 0);
        check("fl_dep_ready", in_ready, 1);
        step();
        @(negedge clk);
        check("fl_dep_issued", out_valid, 1);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step();
            reset         = ($urandom_range(399) != 0);
            in_valid      = ($urandom_range(3) != 0);
            in_instr      = mk($urandom_range(7), $urandom_range(7), 16'($urandom));
            in_ctrl       = 16'($urandom);
            in_alu_src    = 1'($urandom);
            in_ext_op     = 1'($urandom);
            in_imm_zero   = ($urandom_range(7) == 0);
            in_reg_dst    = 1'($urandom);
            in_reg_wr     = 1'($urandom);
            in_mem_to_reg = ($urandom_range(2) == 0);
            wb_en         = 1'($urandom);
            wb_addr       = 5'($urandom_range(7));
            wb_data       = $urandom;
            flush         = ($urandom_range(19) == 0);
            out_ready     = ($urandom_range(3) != 0);
        end
        step();
        idle();
        reset = 1;
        repeat (3) step();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
